mic_direction_tracker: RTL

//  Sits directly downstream of the two per-mic amplitude integrators (left, right).

---
 rtl/mic_direction_tracker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mic_direction_tracker.sv
// Pairs left/right amplitude frames and steers an 8-bit pan position toward the louder mic.
// Optional SMOOTH_EN macro averages the last four paired values per channel before comparing.
module mic_direction_tracker #(
    parameter int unsigned DEADBAND  = 200,
    parameter int unsigned STEP      = 4,
    parameter logic [7:0]  POS_RESET = 8'd128,
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] amp_l,
    input  logic        done_l,
    input  logic [15:0] amp_r,
    input  logic        done_r,
    output logic [7:0]  position,
    output logic [1:0]  dir,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CMP  = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_SILENT = 2'b00,
        DIR_LEFT   = 2'b01,
        DIR_RIGHT  = 2'b10,
        DIR_CENTRE = 2'b11
    } dir_t;

    state_t                state_q, state_d;
    logic                  done_l_q, done_r_q;
    logic [15:0]           cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic                  have_l_q, have_l_d, have_r_q, have_r_d;
    logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
    logic [15:0]           wl_q, wl_d, wr_q, wr_d;
    logic signed [16:0]    diff_q, diff_d;
    logic [7:0]            pos_q, pos_d;
    dir_t                  dir_q, dir_d;

    logic                  rise_l, rise_r;
    logic                  pair_go, one_have, tmo_hit;
    logic [15:0]           pair_l, pair_r;
    logic [16:0]           abs_diff;
    logic [8:0]            pos_dn, pos_up;
    logic [7:0]            upd_pos;
    dir_t                  upd_dir;
    logic                  upd_show;

    assign rise_l   = done_l & ~done_l_q;
    assign rise_r   = done_r & ~done_r_q;
    assign pair_go  = (state_q == ST_WAIT) && have_l_q && have_r_q;
    assign one_have = have_l_q ^ have_r_q;
    assign tmo_hit  = (state_q == ST_WAIT) && one_have && (tcnt_q == TIMEOUT_W'(TIMEOUT - 1));

`ifdef SMOOTH_EN
    // Three older samples plus the incoming capture form the 4-deep averaging window.
    logic [15:0] hist_l_q [3];
    logic [15:0] hist_r_q [3];
    logic [15:0] hist_l_d [3];
    logic [15:0] hist_r_d [3];
    logic [17:0] sum_l, sum_r;

    always_comb begin
        sum_l    = 18'(cap_l_q) + 18'(hist_l_q[0]) + 18'(hist_l_q[1]) + 18'(hist_l_q[2]);
        sum_r    = 18'(cap_r_q) + 18'(hist_r_q[0]) + 18'(hist_r_q[1]) + 18'(hist_r_q[2]);
        pair_l   = 16'(sum_l >> 2);
        pair_r   = 16'(sum_r >> 2);
        hist_l_d = hist_l_q;
        hist_r_d = hist_r_q;
        if (pair_go) begin
            hist_l_d[0] = cap_l_q;
            hist_l_d[1] = hist_l_q[0];
            hist_l_d[2] = hist_l_q[1];
            hist_r_d[0] = cap_r_q;
            hist_r_d[1] = hist_r_q[0];
            hist_r_d[2] = hist_r_q[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this history is reset deliberately; the average must ramp up from zero.
            for (int i = 0; i < 3; i++) begin
                hist_l_q[i] <= '0;
                hist_r_q[i] <= '0;
            end
        end else begin
            hist_l_q <= hist_l_d;
            hist_r_q <= hist_r_d;
        end
    end
`else
    always_comb begin
        pair_l = cap_l_q;
        pair_r = cap_r_q;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_WAIT;
            done_l_q <= 1'b0;
            done_r_q <= 1'b0;
            cap_l_q  <= '0;
            cap_r_q  <= '0;
            have_l_q <= 1'b0;
            have_r_q <= 1'b0;
            tcnt_q   <= '0;
            wl_q     <= '0;
            wr_q     <= '0;
            diff_q   <= '0;
            pos_q    <= POS_RESET;
            dir_q    <= DIR_SILENT;
        end else begin
            // NOTE: non-blocking so every flop samples the values from before this edge.
            state_q  <= state_d;
            done_l_q <= done_l;
            done_r_q <= done_r;
            cap_l_q  <= cap_l_d;
            cap_r_q  <= cap_r_d;
            have_l_q <= have_l_d;
            have_r_q <= have_r_d;
            tcnt_q   <= tcnt_d;
            wl_q     <= wl_d;
            wr_q     <= wr_d;
            diff_q   <= diff_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (have_l_q && have_r_q) state_d = ST_CMP;
            ST_CMP:  state_d = ST_UPD;
            ST_UPD:  state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // Capture, pairing and timeout bookkeeping; a same-cycle rise beats any clear.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        cap_l_d  = rise_l ? amp_l : cap_l_q;
        cap_r_d  = rise_r ? amp_r : cap_r_q;
        have_l_d = have_l_q;
        have_r_d = have_r_q;
        if (pair_go || tmo_hit) begin
            have_l_d = 1'b0;
            have_r_d = 1'b0;
        end
        if (rise_l) have_l_d = 1'b1;
        if (rise_r) have_r_d = 1'b1;

        tcnt_d = tcnt_q;
        if ((!have_l_q && !have_r_q) || pair_go || tmo_hit) begin
            tcnt_d = '0;
        end else if ((state_q == ST_WAIT) && one_have) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        wl_d   = pair_go ? pair_l : wl_q;
        wr_d   = pair_go ? pair_r : wr_q;
        diff_d = (state_q == ST_CMP) ? $signed({1'b0, wl_q} - {1'b0, wr_q}) : diff_q;
    end

    // Update decision from the registered difference; 9-bit sums keep position from wrapping.
    always_comb begin
        abs_diff = diff_q[16] ? unsigned'(-diff_q) : unsigned'(diff_q);
        pos_dn   = {1'b0, pos_q} - 9'(STEP);
        pos_up   = {1'b0, pos_q} + 9'(STEP);
        upd_pos  = pos_q;
        upd_dir  = DIR_SILENT;
        if ((wl_q == '0) && (wr_q == '0)) begin
            upd_dir = DIR_SILENT;
        end else if (abs_diff <= 17'(DEADBAND)) begin
            upd_dir = DIR_CENTRE;
        end else if (!diff_q[16]) begin
            upd_dir = DIR_LEFT;
            upd_pos = pos_dn[8] ? 8'd0 : pos_dn[7:0];
        end else begin
            upd_dir = DIR_RIGHT;
            upd_pos = pos_up[8] ? 8'd255 : pos_up[7:0];
        end
        pos_d = (state_q == ST_UPD) ? upd_pos : pos_q;
        dir_d = (state_q == ST_UPD) ? upd_dir : dir_q;
    end

    always_comb begin
        upd_show = (state_q == ST_UPD) && !reset;
        valid    = upd_show;
        timeout  = tmo_hit && !reset;
        position = upd_show ? upd_pos : pos_q;
        dir      = upd_show ? upd_dir : dir_q;
    end

endmodule
